// File: rtl/param_register_file.sv
// Register bank, DEPTH x WIDTH, with one write port, two combinational read ports and a shift (delay-line) mode.
// Latency: writes are visible on the read ports one edge later; reads are combinational.
// Backpressure: none, the bank accepts every update. Optional write-through reads under REGFILE_BYPASS_EN.
module param_register_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [WIDTH-1:0]  shift_out
);

  logic [WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0] wr_sel;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] shift_src;
      logic             en;

      if (i == 0) begin : g_head
        assign shift_src = wr_data;
      end else begin : g_tap
        assign shift_src = entry[i-1];
      end

      // Out-of-range write addresses match no entry, so they are dropped here.
      assign wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
      assign en        = clear || shift_en || wr_sel[i];
      assign d         = clear ? '0 : (shift_en ? shift_src : wr_data);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q <= '0;
        end else if (en) begin
          q <= d;
        end
      end

      assign entry[i] = q;
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = reset && !shift_en && !clear && (|wr_sel);
`endif

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr_a == ADDR_W'(k)) rd_data_a = entry[k];
      if (rd_addr_b == ADDR_W'(k)) rd_data_b = entry[k];
    end
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (byp_ok && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
`endif
  end

  assign shift_out = entry[DEPTH-1];

endmodule

// File: tb/tb_param_register_file.sv
// Randomised scoreboard bench for param_register_file: DEPTH=8 and DEPTH=6 instances driven in parallel.
module tb_param_register_file;

  logic       clk = 1'b0;
  logic       reset, clear, shift_en, wr_en;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data;
  logic [7:0] rd_a8, rd_b8, tail8, rd_a6, rd_b6, tail6;

  always #5 clk = ~clk;

  param_register_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a8),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b8), .shift_out(tail8));

  param_register_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a6),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b6), .shift_out(tail6));

  typedef struct packed {
    logic [7:0] a8, b8, t8, a6, b6, t6;
  } exp_t;

  exp_t       exp_q[$];
  string      nm_q[$];
  event       present;
  int         errors = 0;
  int         checks = 0;

  // Reference contents: model index 0 is the DEPTH=8 bank, index 1 the DEPTH=6 bank.
  logic [7:0] m [2][8];
  int         dep [2] = '{8, 6};

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h expected=%h at %0t", nm, fld, act, exp, $time);
    end
  endtask

  always begin
    exp_t  e;
    string nm;
    @(present);
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      chk(nm, "a8", rd_a8, e.a8);
      chk(nm, "b8", rd_b8, e.b8);
      chk(nm, "t8", tail8, e.t8);
      chk(nm, "a6", rd_a6, e.a6);
      chk(nm, "b6", rd_b6, e.b6);
      chk(nm, "t6", tail6, e.t6);
    end
  end

  function automatic logic [7:0] exp_rd(input int k, input logic [2:0] addr);
    logic [7:0] v;
    v = (int'(addr) < dep[k]) ? m[k][addr] : 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (reset && wr_en && !shift_en && !clear && int'(wr_addr) < dep[k] && addr == wr_addr)
      v = wr_data;
`endif
    return v;
  endfunction

  task automatic push_exp(input string nm);
    exp_t e;
    e.a8 = exp_rd(0, rd_addr_a);
    e.b8 = exp_rd(0, rd_addr_b);
    e.t8 = m[0][dep[0]-1];
    e.a6 = exp_rd(1, rd_addr_a);
    e.b6 = exp_rd(1, rd_addr_b);
    e.t6 = m[1][dep[1]-1];
    exp_q.push_back(e);
    nm_q.push_back(nm);
    -> present;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 8; j++) m[k][j] = 8'h00;
  endtask

  // Applies the update that the clock edge just performed with the inputs still held.
  task automatic model_edge();
    if (!reset) return;
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        for (int j = 0; j < dep[k]; j++) m[k][j] = 8'h00;
      end else if (shift_en) begin
        for (int j = dep[k] - 1; j > 0; j--) m[k][j] = m[k][j-1];
        m[k][0] = wr_data;
      end else if (wr_en && int'(wr_addr) < dep[k]) begin
        m[k][wr_addr] = wr_data;
      end
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic c, input logic s, input logic w, input logic [2:0] wa,
                     input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                     input string nm);
    clear = c; shift_en = s; wr_en = w; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    #2;
    push_exp(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rst_pulse(input string nm);
    clear = 1'b0; shift_en = 1'($urandom % 2); wr_en = 1'b1;
    wr_addr = 3'($urandom); wr_data = 8'($urandom | 1);
    rd_addr_a = 3'($urandom); rd_addr_b = 3'($urandom);
    reset = 1'b0;
    #2;
    model_clear();
    push_exp(nm);
    @(posedge clk);
    #1;
    clear = 1'b0; shift_en = 1'b0; wr_en = 1'b0;
    reset = 1'b1;
    #2;
    push_exp(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       c, s, w;
    logic [2:0] wa, ra, rb;
    reset = 1'b0; clear = 1'b0; shift_en = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    push_exp("reset_rel");
    @(posedge clk);
    #1;

    cyc(0, 0, 1, 3'd3, 8'hA5, 3'd0, 3'd0, "wr3");
    cyc(0, 0, 0, 3'd0, 8'h00, 3'd3, 3'd3, "rd3");
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 3'd0, 8'h00, 3'(k), 3'(7 - k), "scan");

    cyc(0, 0, 1, 3'd2, 8'h11, 3'd0, 3'd1, "coll_w1");
    cyc(0, 0, 1, 3'd2, 8'h22, 3'd2, 3'd3, "coll_w2");
    cyc(0, 0, 0, 3'd0, 8'h00, 3'd2, 3'd2, "coll_after");

    for (int k = 1; k <= 8; k++) cyc(0, 1, 0, 3'd0, 8'(k), 3'd0, 3'd7, "shift");
    cyc(0, 1, 0, 3'd0, 8'h09, 3'd0, 3'd7, "shift9");
    cyc(0, 0, 0, 3'd0, 8'h00, 3'd0, 3'd7, "shift_post");

    cyc(1, 1, 1, 3'd3, 8'hFF, 3'd3, 3'd0, "clr_all");
    cyc(0, 0, 0, 3'd0, 8'h00, 3'd3, 3'd7, "clr_post");

    cyc(0, 0, 1, 3'd7, 8'hFF, 3'd7, 3'd6, "oor_wr");
    cyc(0, 0, 1, 3'd6, 8'hEE, 3'd6, 3'd5, "oor_wr6");
    cyc(0, 0, 0, 3'd0, 8'h00, 3'd6, 3'd7, "oor_rd");

    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 3'(k), 8'(8'h30 + k), 3'(k), 3'd0, "fill");
    rst_pulse("async_rst");
    cyc(0, 0, 0, 3'd0, 8'h00, 3'd5, 3'd7, "rst_post");

    repeat (600) begin
      if ($urandom % 64 == 0) begin
        rst_pulse("rand_rst");
      end else begin
        c  = ($urandom % 16 == 0);
        s  = ($urandom % 4 == 0);
        w  = 1'($urandom % 2);
        wa = 3'($urandom);
        ra = 3'($urandom);
        rb = 3'($urandom);
        if ($urandom % 3 == 0) ra = wa;
        if ($urandom % 5 == 0) rb = wa;
        cyc(c, s, w, wa, 8'($urandom), ra, rb, "rand");
      end
    end

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
